// File: rtl/count_seq_monitor.sv
// Checker for the upstream 3-bit period-4 counter (0->3->5->6->0): tracks lock,
// flags illegal transitions, counts laps and drives an active-low 7-segment decode.
module count_seq_monitor #(
    parameter int LOCK_COUNT = 2,
    parameter int LAP_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       q_in,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic             lap_pulse,
    output logic [LAP_W-1:0] lap_count,
    output logic [6:0]       seg
);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

    state_t     state, state_nxt;
    logic [3:0] run, run_nxt;
    logic [2:0] q_prev;
    logic       legal;
    logic       err_nxt, lap_nxt;

    function automatic logic legal_step(input logic [2:0] prev, input logic [2:0] cur);
        case (prev)
            3'd0:    return cur == 3'd3;
            3'd3:    return cur == 3'd5;
            3'd5:    return cur == 3'd6;
            3'd6:    return cur == 3'd0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [6:0] seg_decode(input logic [2:0] code);
        case (code)
            3'd0:    return 7'h40;
            3'd3:    return 7'h30;
            3'd5:    return 7'h12;
            3'd6:    return 7'h02;
            default: return 7'h3F;
        endcase
    endfunction

    // A hold is illegal too: the successor of a code is never the code itself.
    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        err_nxt   = 1'b0;
        lap_nxt   = 1'b0;
        legal     = legal_step(q_prev, q_in);
        case (state)
            IDLE: begin
                state_nxt = ACQUIRE;
                run_nxt   = 4'd0;
            end
            ACQUIRE: begin
                if (legal) begin
                    run_nxt = run + 4'd1;
                    if (run + 4'd1 == LOCK_N)
                        state_nxt = LOCKED;
                end else begin
                    run_nxt = 4'd0;
                end
            end
            LOCKED: begin
                if (legal) begin
                    lap_nxt = (q_prev == 3'd6) && (q_in == 3'd0);
                end else begin
                    err_nxt   = 1'b1;
                    state_nxt = ACQUIRE;
                    run_nxt   = 4'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                run_nxt   = 4'd0;
            end
        endcase
    end

    // clr loses to a simultaneous error set but beats a simultaneous lap increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            run        <= 4'd0;
            q_prev     <= 3'd0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            lap_pulse  <= 1'b0;
            lap_count  <= '0;
            seg        <= 7'h40;
        end else begin
            state     <= state_nxt;
            run       <= run_nxt;
            q_prev    <= q_in;
            locked    <= (state_nxt == LOCKED);
            err_pulse <= err_nxt;
            lap_pulse <= lap_nxt;
            seg       <= seg_decode(q_in);
            if (clr)
                lap_count <= '0;
            else if (lap_nxt)
                lap_count <= lap_count + 1'b1;
            if (err_nxt)
                err_sticky <= 1'b1;
            else if (clr)
                err_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_count_seq_monitor.sv
// Bench for count_seq_monitor: streak-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_count_seq_monitor;

    localparam int LOCK_COUNT = 2;
    localparam int LAP_W      = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       q_in = 3'd0;
    logic             clr = 1'b0;
    logic             locked, err_pulse, err_sticky, lap_pulse;
    logic [LAP_W-1:0] lap_count;
    logic [6:0]       seg;

    int passes = 0;
    int total  = 0;

    // Reference model: lock means the run of legal transitions since the
    // first post-reset sample has reached LOCK_COUNT.
    int succ_t[8] = '{3, -1, -1, 5, -1, 6, 0, -1};
    int seg_t[8]  = '{'h40, 'h3F, 'h3F, 'h30, 'h3F, 'h12, 'h02, 'h3F};
    int m_n, m_prev, m_streak, m_lap_cnt;
    bit m_sticky, m_err, m_lap, m_locked;
    int m_seg;

    count_seq_monitor #(.LOCK_COUNT(LOCK_COUNT), .LAP_W(LAP_W)) dut (
        .clk(clk), .reset(reset), .q_in(q_in), .clr(clr),
        .locked(locked), .err_pulse(err_pulse), .err_sticky(err_sticky),
        .lap_pulse(lap_pulse), .lap_count(lap_count), .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            passes++;
    endtask

    task automatic model_reset();
        m_n = 0; m_prev = 0; m_streak = 0; m_lap_cnt = 0;
        m_sticky = 0; m_err = 0; m_lap = 0; m_locked = 0; m_seg = 'h40;
    endtask

    task automatic model_step(input int cur, input bit c);
        bit was_locked;
        was_locked = (m_n > 0) && (m_streak >= LOCK_COUNT);
        m_err = 0;
        m_lap = 0;
        if (m_n == 0) begin
            m_streak = 0;
        end else if (succ_t[m_prev] == cur) begin
            m_lap = was_locked && (m_prev == 6) && (cur == 0);
            if (m_streak < 1000) m_streak++;
        end else begin
            m_err = was_locked;
            m_streak = 0;
        end
        m_locked = (m_n > 0) && (m_streak >= LOCK_COUNT);
        if (c) m_lap_cnt = 0;
        else if (m_lap) m_lap_cnt = (m_lap_cnt + 1) % (1 << LAP_W);
        if (m_err) m_sticky = 1;
        else if (c) m_sticky = 0;
        m_seg = seg_t[cur];
        m_prev = cur;
        if (m_n < 1000) m_n++;
    endtask

    always @(posedge reset) model_reset();

    always @(posedge clk) begin
        if (reset) model_reset();
        else model_step(int'(q_in), clr);
        #1;
        check("locked", locked, m_locked);
        check("err_pulse", err_pulse, m_err);
        check("err_sticky", err_sticky, m_sticky);
        check("lap_pulse", lap_pulse, m_lap);
        check("lap_count", lap_count, m_lap_cnt);
        check("seg", seg, m_seg);
        check("pulse_excl", err_pulse & lap_pulse, 0);
        check("err_implies_unlocked", err_pulse & locked, 0);
    end

    task automatic step(input int q, input bit c);
        @(negedge clk);
        q_in = 3'(q);
        clr  = c;
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_err"}, err_pulse, 0);
        check({tag, "_sticky"}, err_sticky, 0);
        check({tag, "_lap"}, lap_pulse, 0);
        check({tag, "_count"}, lap_count, 0);
        check({tag, "_seg"}, seg, 'h40);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_reset_vals("por");
        @(negedge clk) reset = 1'b0;

        // Lock acquisition
        step(0, 0); check("acq_e1_locked", locked, 0);
        step(3, 0); check("acq_e2_locked", locked, 0);
        step(5, 0);
        check("acq_locked", locked, 1);
        check("acq_seg", seg, 'h12);
        check("acq_no_err", err_pulse, 0);
        check("acq_no_lap", lap_pulse, 0);

        // Lap counting and wrap
        step(6, 0);
        step(0, 0);
        check("lap1_pulse", lap_pulse, 1);
        check("lap1_count", lap_count, 1);
        step(3, 0);
        check("lap1_pulse_drop", lap_pulse, 0);
        step(5, 0); step(6, 0); step(0, 0);
        for (int i = 0; i < 254; i++) begin
            step(3, 0); step(5, 0); step(6, 0); step(0, 0);
        end
        check("wrap_pulse", lap_pulse, 1);
        check("wrap_count", lap_count, 0);

        // Error while locked, then relock
        step(3, 0); step(5, 0);
        step(7, 0);
        check("err_pulse", err_pulse, 1);
        check("err_sticky", err_sticky, 1);
        check("err_unlock", locked, 0);
        check("err_seg", seg, 'h3F);
        step(0, 0); check("err_pulse_drop", err_pulse, 0);
        step(3, 0);
        step(5, 0);
        check("relock", locked, 1);
        check("relock_sticky", err_sticky, 1);

        // Hold inside ACQUIRE
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        step(0, 0); step(3, 0);
        step(3, 0); check("hold_no_err", err_pulse, 0);
        step(5, 0); check("hold_not_locked", locked, 0);
        step(6, 0);
        check("hold_lock_after6", locked, 1);
        check("hold_no_err2", err_pulse, 0);

        // Clear priority
        step(0, 0); check("clr_pre_count", lap_count, 1);
        step(3, 0); step(5, 0); step(6, 0);
        step(0, 1);
        check("clr_lap_pulse", lap_pulse, 1);
        check("clr_lap_count", lap_count, 0);
        step(3, 0); step(5, 0);
        step(2, 1);
        check("clr_err_pulse", err_pulse, 1);
        check("clr_err_sticky", err_sticky, 1);
        step(0, 1);
        check("clr_sticky_cleared", err_sticky, 0);

        // Async reset mid-lap
        step(3, 0); step(5, 0);
        for (int k = 0; k < 5; k++) begin
            step(6, 0); step(0, 0);
            if (k < 4) begin step(3, 0); step(5, 0); end
        end
        check("pre_rst_count", lap_count, 5);
        check("pre_rst_locked", locked, 1);
        step(3, 0);
        reset = 1'b1;
        #1;
        check_reset_vals("async");
        @(negedge clk) reset = 1'b0;
        step(0, 0); step(3, 0);
        step(5, 0);
        check("post_rst_lock", locked, 1);

        repeat (2) @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
